// File: rtl/crc_tx_pkg.sv
// Shared definitions for the serial CRC frame transmitter.
// Holds the transmitter state encoding and the default word / CRC widths.
// Ports: none (package).
package crc_tx_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CRC_WIDTH  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CRC_WAIT,
    CRC_OUT,
    FLUSH
  } state_t;

endpackage

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shift register, LSB first.
// Ports: CLK/RST clock and async active-high reset; load captures din;
//        shift moves the register right one bit; dout is the current LSB.
module piso_shifter
  import crc_tx_pkg::*;
#(
  parameter int W = DEF_DATA_WIDTH
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         dout
);

  logic [W-1:0] sreg;

  // load wins over shift so a back-to-back word replaces the spent one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= {1'b0, sreg[W-1:1]};
    end
  end

  assign dout = sreg[0];

endmodule

// File: rtl/crc_frame_tx.sv
// Serialises payload words LSB first toward an external CRC block, then
// forwards that block's serial CRC onto the line; an underrun flushes the CRC.
// Ports: byte_* word handshake in; ser_data/ser_active to CRC block;
//        crc_bit/crc_valid from CRC block; tx_out/tx_en line; busy/done/err status.
module crc_frame_tx
  import crc_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CRC_WIDTH  = DEF_CRC_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] byte_data,
  input  logic                  byte_valid,
  input  logic                  byte_last,
  output logic                  byte_ready,
  output logic                  ser_data,
  output logic                  ser_active,
  input  logic                  crc_bit,
  input  logic                  crc_valid,
  output logic                  tx_out,
  output logic                  tx_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // The counter must reach CRC_WIDTH in FLUSH and DATA_WIDTH-1 in SHIFT.
  localparam int CNT_MAX = (DATA_WIDTH > CRC_WIDTH + 1) ? DATA_WIDTH : CRC_WIDTH + 1;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CRC_LAST   = CNT_W'(CRC_WIDTH - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(CRC_WIDTH);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             last_flag, last_nx;
  logic             load, shift, ready_int;
  logic             sout;

  piso_shifter #(.W(DATA_WIDTH)) u_piso (
    .CLK   (CLK),
    .RST   (RST),
    .load  (load),
    .shift (shift),
    .din   (byte_data),
    .dout  (sout)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      last_flag <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      last_flag <= last_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    last_nx   = last_flag;
    load      = 1'b0;
    shift     = 1'b0;
    ready_int = 1'b0;
    case (state)
      IDLE: begin
        ready_int = 1'b1;
        if (byte_valid) begin
          load     = 1'b1;
          last_nx  = byte_last;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == BIT_LAST) begin
          // Only the final bit of a non-last word can take the next word,
          // which keeps the payload stream gap-free.
          ready_int = ~last_flag;
          cnt_nx    = '0;
          if (last_flag) begin
            state_nx = CRC_WAIT;
          end else if (byte_valid) begin
            load    = 1'b1;
            last_nx = byte_last;
          end else begin
            state_nx = FLUSH;
          end
        end else begin
          shift  = 1'b1;
          cnt_nx = cnt + 1'b1;
        end
      end
      CRC_WAIT: begin
        if (crc_valid) begin
          cnt_nx   = '0;
          state_nx = CRC_OUT;
        end
      end
      CRC_OUT: begin
        if (cnt == CRC_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      FLUSH: begin
        // Drain the CRC block's output without putting it on the line.
        if (cnt == FLUSH_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // All outputs decode registered state; byte_valid never reaches them.
  // Reset holds state at IDLE, so only byte_ready needs explicit masking.
  assign byte_ready = ready_int & ~RST;
  assign ser_active = (state == SHIFT);
  assign ser_data   = ser_active & sout;
  assign tx_en      = (state == SHIFT) | (state == CRC_OUT);
  assign tx_out     = ((state == SHIFT) & sout) | ((state == CRC_OUT) & crc_bit);
  assign busy       = (state != IDLE);
  assign done       = (state == CRC_OUT) & (cnt == CRC_LAST);
  assign err        = (state == FLUSH) & (cnt == '0);

endmodule

// File: tb/tb_crc_frame_tx.sv
// Directed self-checking bench for crc_frame_tx (8-bit words, 8-bit CRC).
// Ports: none; the bench plays the word source and the CRC block.
module tb_crc_frame_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] byte_data;
  logic       byte_valid, byte_last, crc_bit, crc_valid;
  logic       byte_ready, ser_data, ser_active, tx_out, tx_en, busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  crc_frame_tx #(.DATA_WIDTH(8), .CRC_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .ser_data   (ser_data),
    .ser_active (ser_active),
    .crc_bit    (crc_bit),
    .crc_valid  (crc_valid),
    .tx_out     (tx_out),
    .tx_en      (tx_en),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 CLK = ~CLK;

  wire [7:0] obs = {byte_ready, ser_active, ser_data, tx_en, tx_out, busy, done, err};

  function automatic logic [7:0] ev(input logic rdy, input logic sa, input logic sd,
                                    input logic te, input logic to, input logic bz,
                                    input logic dn, input logic er);
    return {rdy, sa, sd, te, to, bz, dn, er};
  endfunction

  task automatic chk(input string tag, input logic [7:0] e);
    n_cmp++;
    assert (obs === e)
    else begin
      n_bad++;
      $error("FAIL %s: observed %b required %b (rdy sa sd te to busy done err)", tag, obs, e);
    end
  endtask

  // Checks the IDLE cycle, then presents a word for acceptance on the next edge.
  task automatic idle_accept(input string tag, input logic [7:0] d, input logic last);
    @(negedge CLK);
    chk({tag, "_idle"}, ev(1, 0, 0, 0, 0, 0, 0, 0));
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = last;
  endtask

  // Checks the eight payload bit cycles of word d; the word source drives
  // (nv, nd, nl) throughout, so only the bit-7 cycle may consume it.
  task automatic shift_word(input string tag, input logic [7:0] d, input logic last,
                            input logic nv, input logic [7:0] nd, input logic nl);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk($sformatf("%s_b%0d", tag, i), ev((i == 7) && !last, 1, d[i], 1, d[i], 1, 0, 0));
      byte_valid = nv;
      byte_data  = nd;
      byte_last  = nl;
    end
  endtask

  // nwait CRC_WAIT cycles (crc_valid rises on the last), then 8 CRC bits p LSB first.
  task automatic crc_phase(input string tag, input int nwait, input logic [7:0] p);
    for (int k = 0; k < nwait; k++) begin
      @(negedge CLK);
      crc_bit = 1'b1;
      #1;
      chk($sformatf("%s_wait%0d", tag, k), ev(0, 0, 0, 0, 0, 1, 0, 0));
      crc_valid = (k == nwait - 1);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      crc_bit = p[i];
      #1;
      chk($sformatf("%s_crc%0d", tag, i), ev(0, 0, 0, 1, p[i], 1, i == 7, 0));
    end
    crc_valid = 1'b0;
    crc_bit   = 1'b0;
  endtask

  task automatic flush(input string tag);
    crc_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      crc_bit = 1'b1;
      #1;
      chk($sformatf("%s_flush%0d", tag, i), ev(0, 0, 0, 0, 0, 1, 0, i == 0));
    end
    crc_valid = 1'b0;
    crc_bit   = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    RST        = 1'b1;
    byte_data  = 8'h00;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    crc_bit    = 1'b0;
    crc_valid  = 1'b0;

    // Reset: everything low, byte_ready included, even with valid offered.
    @(negedge CLK);
    byte_valid = 1'b1;
    #1;
    chk("reset", ev(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge CLK);
    byte_valid = 1'b0;
    RST = 1'b0;
    #1;
    chk("release", ev(1, 0, 0, 0, 0, 0, 0, 0));

    // Single last word 0xA5, one-cycle CRC wait, CRC 0x96.
    idle_accept("t1", 8'hA5, 1'b1);
    shift_word("t1", 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
    crc_phase("t1", 1, 8'h96);

    // Back-to-back frame: 0x01 then 0x80 (last) with no gap; CRC wait stretched.
    idle_accept("t2", 8'h01, 1'b0);
    shift_word("t2a", 8'h01, 1'b0, 1'b1, 8'h80, 1'b1);
    shift_word("t2b", 8'h80, 1'b1, 1'b0, 8'h00, 1'b0);
    crc_phase("t2", 3, 8'h3C);

    // Underrun: 0x3C non-last, nothing follows -> err then 9 flush cycles.
    idle_accept("t3", 8'h3C, 1'b0);
    shift_word("t3", 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
    flush("t3");

    // Valid held high with 0xAA during 0x55: only the bit-7 cycle takes it.
    idle_accept("t4", 8'h55, 1'b0);
    shift_word("t4a", 8'h55, 1'b0, 1'b1, 8'hAA, 1'b0);
    shift_word("t4b", 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0);
    flush("t4");

    // Reset on bit 3 of 0x5A abandons the frame.
    idle_accept("t5", 8'h5A, 1'b1);
    w = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk($sformatf("t5_b%0d", i), ev(0, 1, w[i], 1, w[i], 1, 0, 0));
      byte_valid = 1'b0;
    end
    RST = 1'b1;
    #1;
    chk("t5_rst_async", ev(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge CLK);
    chk("t5_rst_hold", ev(0, 0, 0, 0, 0, 0, 0, 0));
    RST = 1'b0;
    #1;
    chk("t5_release", ev(1, 0, 0, 0, 0, 0, 0, 0));

    // Frame after the abandoned one: 0xFF, CRC 0x00.
    idle_accept("t6", 8'hFF, 1'b1);
    shift_word("t6", 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);
    crc_phase("t6", 1, 8'h00);
    @(negedge CLK);
    chk("t6_end_idle", ev(1, 0, 0, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
